// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared types and constants for the execute-stage ALU control decoder and
// the iterative RV32M multiply/divide engine.
package alu_pkg;

  localparam int unsigned ALU_CW = 4;

  typedef enum logic [ALU_CW-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_INV  = 4'b1111
  } alu_ctrl_e;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ALU    = 2'b10;
  localparam logic [1:0] ALUOP_INV    = 2'b11;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Operand a is treated as signed for every op except the unsigned variants.
  function automatic logic md_signed_a(input logic [2:0] f3);
    return !((f3 == F3_MULHU) || (f3 == F3_DIVU) || (f3 == F3_REMU));
  endfunction

  function automatic logic md_signed_b(input logic [2:0] f3);
    return md_signed_a(f3) && (f3 != F3_MULHSU);
  endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// Execute-stage bundle between the pipeline and the ALU control / muldiv unit.
interface alu_ctrl_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  import alu_pkg::*;

  logic [1:0]        ALUOp;
  logic              op5;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              in_valid;
  logic              flush;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic [ALU_CW-1:0] ALUControl;
  logic              md_sel;
  logic              stall;
  logic              md_busy;
  logic              md_done;
  logic [XLEN-1:0]   md_result;

  modport master (
    output ALUOp, op5, funct3, funct7, in_valid, flush, src_a, src_b,
    input  ALUControl, md_sel, stall, md_busy, md_done, md_result
  );

  modport slave (
    input  ALUOp, op5, funct3, funct7, in_valid, flush, src_a, src_b,
    output ALUControl, md_sel, stall, md_busy, md_done, md_result
  );

endinterface

// File: rtl/alu_ctrl_muldiv_iter.sv
// Iterative multiply/divide engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up on the final iteration.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNTW = $clog2(XLEN) + 1;
  localparam int unsigned PW   = 2 * XLEN;

  md_state_e       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;

  // Request decode: signs, magnitudes and the two divide shortcuts.
  logic            a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign a_neg    = md_signed_a(funct3_i) & src_a_i[XLEN-1];
  assign b_neg    = md_signed_b(funct3_i) & src_b_i[XLEN-1];
  assign mag_a    = a_neg ? (~src_a_i + XLEN'(1)) : src_a_i;
  assign mag_b    = b_neg ? (~src_b_i + XLEN'(1)) : src_b_i;
  assign is_div   = funct3_i[2];
  assign div_zero = is_div && (src_b_i == '0);
  assign div_ovf  = is_div && !funct3_i[0] &&
                    (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);

  // Multiply step: add multiplicand into the high half when the multiplier lsb is set, then shift right.
  logic [XLEN:0]   add_sum;
  logic [PW-1:0]   mul_next;
  assign add_sum  = {1'b0, acc_q[PW-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next = {add_sum, acc_q[XLEN-1:1]};

  // Divide step: high half is the partial remainder, low half shifts the dividend out and quotient in.
  logic [XLEN:0]   trial;
  logic [PW-1:0]   div_next;
  assign trial    = {acc_q[PW-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
  assign div_next = trial[XLEN] ? {acc_q[PW-2:0], 1'b0}
                                : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] mul_fin, quo_fix, rem_fix, div_fin, fin;
  assign prod_fix = neg_q ? (~mul_next + PW'(1)) : mul_next;
  assign mul_fin  = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
  assign quo_fix  = neg_q  ? (~div_next[XLEN-1:0] + XLEN'(1)) : div_next[XLEN-1:0];
  assign rem_fix  = rneg_q ? (~div_next[PW-1:XLEN] + XLEN'(1)) : div_next[PW-1:XLEN];
  assign div_fin  = f3_q[1] ? rem_fix : quo_fix;
  assign fin      = (state_q == MD_MUL) ? mul_fin : div_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          f3_d   = funct3_i;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (div_zero) begin
            result_d = funct3_i[1] ? src_a_i : '1;
            state_d  = MD_DONE;
          end else if (div_ovf) begin
            result_d = funct3_i[1] ? '0 : src_a_i;
            state_d  = MD_DONE;
          end else if (is_div) begin
            opnd_d  = mag_b;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            cnt_d   = CNTW'(XLEN);
            state_d = MD_DIV;
          end else begin
            opnd_d  = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            cnt_d   = CNTW'(XLEN);
            state_d = MD_MUL;
          end
        end
      end
      MD_MUL, MD_DIV: begin
        acc_d = (state_q == MD_MUL) ? mul_next : div_next;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          result_d = fin;
          state_d  = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    // Abort wins over everything, including acceptance; the previous result is kept.
    if (flush_i) begin
      state_d  = MD_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign busy_o   = (state_q != MD_IDLE);
  assign done_o   = (state_q == MD_DONE);
  assign result_o = result_q;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// Execute-stage ALU control: 4-bit ALUControl decoder, RV32M selection and
// pipeline stall glue around the iterative multiply/divide engine.
module alu_ctrl_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CW   = ALU_CW
) (
  input logic               clk,
  input logic               rst_n,
  alu_ctrl_muldiv_if.slave  bus
);

  alu_ctrl_e ctrl_c;
  logic      md_sel_c;
  logic      md_start_c;

  assign md_sel_c   = (bus.ALUOp == ALUOP_ALU) && bus.op5 && (bus.funct7 == F7_MULDIV);
  assign md_start_c = bus.in_valid & md_sel_c;

  // ALU operation decode; RV32M instructions park the ALU on add.
  always_comb begin
    ctrl_c = ALU_INV;
    unique case (bus.ALUOp)
      ALUOP_LDST: ctrl_c = ALU_ADD;
      ALUOP_BRANCH: begin
        case (bus.funct3)
          3'b000, 3'b001: ctrl_c = ALU_SUB;
          3'b100, 3'b101: ctrl_c = ALU_SLT;
          3'b110, 3'b111: ctrl_c = ALU_SLTU;
          default:        ctrl_c = ALU_INV;
        endcase
      end
      ALUOP_ALU: begin
        if (md_sel_c) begin
          ctrl_c = ALU_ADD;
        end else begin
          case (bus.funct3)
            3'b000:  ctrl_c = (bus.op5 && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl_c = ALU_SLL;
            3'b010:  ctrl_c = ALU_SLT;
            3'b011:  ctrl_c = ALU_SLTU;
            3'b100:  ctrl_c = ALU_XOR;
            3'b101:  ctrl_c = bus.funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl_c = ALU_OR;
            default: ctrl_c = ALU_AND;
          endcase
        end
      end
      default: ctrl_c = ALU_INV;
    endcase
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start_c),
    .flush_i  (bus.flush),
    .funct3_i (bus.funct3),
    .src_a_i  (bus.src_a),
    .src_b_i  (bus.src_b),
    .busy_o   (bus.md_busy),
    .done_o   (bus.md_done),
    .result_o (bus.md_result)
  );

  assign bus.ALUControl = CW'(ctrl_c);
  assign bus.md_sel     = md_sel_c;
  assign bus.stall      = md_start_c & ~bus.md_done;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed self-checking bench for alu_ctrl_muldiv at XLEN=32 and XLEN=16.
module tb_alu_ctrl_muldiv;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_ctrl_muldiv_if #(.XLEN(32)) bus32 ();
  alu_ctrl_muldiv_if #(.XLEN(16)) bus16 ();

  alu_ctrl_muldiv #(.XLEN(32), .CW(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_ctrl_muldiv #(.XLEN(16), .CW(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Reference ALUControl table.
  function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                          input logic b5, input logic o5);
    logic [3:0] r;
    r = 4'b1111;
    case (op)
      2'b00: r = 4'b0000;
      2'b01: case (f3)
        3'b000, 3'b001: r = 4'b0001;
        3'b100, 3'b101: r = 4'b0101;
        3'b110, 3'b111: r = 4'b1000;
        default:        r = 4'b1111;
      endcase
      2'b10: case (f3)
        3'b000:  r = (o5 && b5) ? 4'b0001 : 4'b0000;
        3'b001:  r = 4'b0110;
        3'b010:  r = 4'b0101;
        3'b011:  r = 4'b1000;
        3'b100:  r = 4'b0100;
        3'b101:  r = b5 ? 4'b1001 : 4'b0111;
        3'b110:  r = 4'b0011;
        default: r = 4'b0010;
      endcase
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Issue one RV32M op on the 32-bit unit and observe done latency, result and stall cycles.
  task automatic do_md32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [31:0] res, output int lat,
                         output int stalls);
    bit seen;
    seen = 0; lat = -1; stalls = 0; res = '0;
    @(negedge clk);
    bus32.ALUOp = 2'b10; bus32.op5 = 1'b1; bus32.funct7 = 7'b0000001; bus32.funct3 = f3;
    bus32.src_a = a; bus32.src_b = b; bus32.in_valid = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (c != 0) @(negedge clk);
      if (scramble && c == 3) begin
        bus32.src_a = ~a; bus32.src_b = b ^ 32'h0000_5A5A;
      end
      #1;
      if (bus32.stall) stalls++;
      if (bus32.md_done) begin
        seen = 1; lat = c; res = bus32.md_result;
      end
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus32.md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus32.md_busy); end
    checks++; if (bus32.md_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus32.md_done); end
    checks++; if (bus32.md_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus32.md_result); end
    checks++; if (bus16.md_result !== 16'h0) begin errors++; $display("FAIL reset_result16 got=%h exp=0", bus16.md_result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus32.md_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", bus32.md_busy); end
    checks++; if (bus32.ALUControl !== 4'b0000) begin errors++; $display("FAIL reset_ldst_ctrl got=%b exp=0000", bus32.ALUControl); end
  endtask

  task automatic test_decode();
    logic [3:0] e;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int b5 = 0; b5 < 2; b5++)
          for (int o5 = 0; o5 < 2; o5++) begin
            bus32.ALUOp = 2'(op); bus32.funct3 = 3'(f3);
            bus32.funct7 = (b5 != 0) ? 7'b0100000 : 7'b0000000; bus32.op5 = 1'(o5);
            #1;
            e = exp_ctrl(2'(op), 3'(f3), 1'(b5), 1'(o5));
            checks++;
            if (bus32.ALUControl !== e || bus32.md_sel !== 1'b0) begin
              errors++;
              $display("FAIL decode op=%0d f3=%0d b5=%0d o5=%0d got=%b/%b exp=%b/0",
                       op, f3, b5, o5, bus32.ALUControl, bus32.md_sel, e);
            end
          end
    bus32.ALUOp = 2'b10; bus32.funct3 = 3'b101; bus32.funct7 = 7'b0100000; bus32.op5 = 1'b1; #1;
    checks++; if (bus32.ALUControl !== 4'b1001) begin errors++; $display("FAIL decode_sra got=%b exp=1001", bus32.ALUControl); end
    bus32.ALUOp = 2'b01; bus32.funct3 = 3'b110; #1;
    checks++; if (bus32.ALUControl !== 4'b1000) begin errors++; $display("FAIL decode_bltu got=%b exp=1000", bus32.ALUControl); end
    bus32.ALUOp = 2'b10; bus32.funct3 = 3'b100; bus32.funct7 = 7'b0000001; bus32.op5 = 1'b1; #1;
    checks++;
    if (bus32.md_sel !== 1'b1 || bus32.ALUControl !== 4'b0000 || bus32.stall !== 1'b0) begin
      errors++; $display("FAIL decode_mdsel got=%b/%b/%b exp=1/0000/0", bus32.md_sel, bus32.ALUControl, bus32.stall);
    end
    bus32.op5 = 1'b0; #1;
    checks++; if (bus32.md_sel !== 1'b0) begin errors++; $display("FAIL decode_mdsel_itype got=%b exp=0", bus32.md_sel); end
    bus32.op5 = 1'b1; bus32.funct7 = 7'b0000000; bus32.in_valid = 1'b1; #1;
    checks++; if (bus32.stall !== 1'b0) begin errors++; $display("FAIL stall_non_md got=%b exp=0", bus32.stall); end
    @(negedge clk);
    bus32.in_valid = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, st;
    do_md32(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++; if (st !== 33) begin errors++; $display("FAIL mul_stall_cycles got=%0d exp=33", st); end
    #1;
    checks++;
    if (bus32.md_result !== 32'hFFFF_FFEB || bus32.md_done !== 1'b0 || bus32.md_busy !== 1'b0) begin
      errors++; $display("FAIL mul_hold got=%h/%b/%b exp=ffffffeb/0/0", bus32.md_result, bus32.md_done, bus32.md_busy);
    end
    do_md32(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1, r, lat, st);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh_result got=%h exp=40000000", r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mulh_latency got=%0d exp=33", lat); end
    do_md32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu_result got=%h exp=ffffffff", r); end
    do_md32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result got=%h exp=fffffffe", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat, st;
    do_md32(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_result got=%h exp=fffffffd", r); end
    checks++; if (lat !== 33 || st !== 33) begin errors++; $display("FAIL div_timing got=%0d/%0d exp=33/33", lat, st); end
    do_md32(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_result got=%h exp=ffffffff", r); end
    do_md32(3'b101, 32'd100, 32'd7, 1'b0, r, lat, st);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_result got=%0d exp=14", r); end
    do_md32(3'b111, 32'd100, 32'd7, 1'b0, r, lat, st);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_result got=%0d exp=2", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat, st;
    do_md32(3'b100, 32'd5, 32'd0, 1'b0, r, lat, st);
    checks++; if (r !== 32'hFFFF_FFFF || lat !== 1 || st !== 1) begin errors++; $display("FAIL div_by_zero got=%h lat=%0d st=%0d exp=ffffffff lat=1 st=1", r, lat, st); end
    do_md32(3'b110, 32'd5, 32'd0, 1'b0, r, lat, st);
    checks++; if (r !== 32'd5 || lat !== 1) begin errors++; $display("FAIL rem_by_zero got=%h lat=%0d exp=5 lat=1", r, lat); end
    do_md32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, lat, st);
    checks++; if (r !== 32'h8000_0000 || lat !== 1) begin errors++; $display("FAIL div_overflow got=%h lat=%0d exp=80000000 lat=1", r, lat); end
    do_md32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, r, lat, st);
    checks++; if (r !== 32'h0 || lat !== 1) begin errors++; $display("FAIL rem_overflow got=%h lat=%0d exp=0 lat=1", r, lat); end
    do_md32(3'b111, 32'd9, 32'd0, 1'b0, r, lat, st);
    checks++; if (r !== 32'd9 || lat !== 1) begin errors++; $display("FAIL remu_by_zero got=%h lat=%0d exp=9 lat=1", r, lat); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat, st; bit done_seen;
    @(negedge clk);
    bus32.ALUOp = 2'b10; bus32.op5 = 1'b1; bus32.funct7 = 7'b0000001; bus32.funct3 = 3'b101;
    bus32.src_a = 32'd100; bus32.src_b = 32'd7; bus32.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus32.flush = 1'b1; bus32.in_valid = 1'b0;
    #1;
    checks++; if (bus32.md_busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got=%b exp=1", bus32.md_busy); end
    @(negedge clk);
    bus32.flush = 1'b0;
    #1;
    checks++; if (bus32.md_busy !== 1'b0) begin errors++; $display("FAIL flush_idle got=%b exp=0", bus32.md_busy); end
    done_seen = bus32.md_done;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus32.md_done) done_seen = 1;
    end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL flush_no_done got=%b exp=0", done_seen); end
    do_md32(3'b000, 32'd12, 32'd13, 1'b0, r, lat, st);
    checks++; if (r !== 32'd156 || lat !== 33) begin errors++; $display("FAIL mul_after_flush got=%0d lat=%0d exp=156 lat=33", r, lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat, st;
    @(negedge clk);
    bus32.ALUOp = 2'b10; bus32.op5 = 1'b1; bus32.funct7 = 7'b0000001; bus32.funct3 = 3'b000;
    bus32.src_a = 32'd3; bus32.src_b = 32'd5; bus32.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus32.md_busy !== 1'b0 || bus32.md_done !== 1'b0 || bus32.md_result !== 32'h0) begin
      errors++; $display("FAIL reset_mid got=%b/%b/%h exp=0/0/0", bus32.md_busy, bus32.md_done, bus32.md_result);
    end
    bus32.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus32.md_busy !== 1'b0 || bus32.md_done !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle got=%b/%b exp=0/0", bus32.md_busy, bus32.md_done);
    end
    do_md32(3'b000, 32'd3, 32'd5, 1'b0, r, lat, st);
    checks++; if (r !== 32'd15 || lat !== 33) begin errors++; $display("FAIL mul_after_reset got=%0d lat=%0d exp=15 lat=33", r, lat); end
  endtask

  task automatic test_xlen16();
    bit seen; int lat; logic [15:0] r;
    seen = 0; lat = -1; r = '0;
    @(negedge clk);
    bus16.ALUOp = 2'b10; bus16.op5 = 1'b1; bus16.funct7 = 7'b0000001; bus16.funct3 = 3'b011;
    bus16.src_a = 16'hFFFF; bus16.src_b = 16'hFFFF; bus16.in_valid = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus16.md_done) begin seen = 1; lat = c; r = bus16.md_result; end
    end
    @(negedge clk);
    bus16.in_valid = 1'b0;
    checks++; if (r !== 16'hFFFE) begin errors++; $display("FAIL x16_mulhu got=%h exp=fffe", r); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL x16_latency got=%0d exp=17", lat); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b1;
    bus32.ALUOp = 2'b00; bus32.op5 = 1'b0; bus32.funct3 = 3'b000; bus32.funct7 = 7'b0;
    bus32.in_valid = 1'b0; bus32.flush = 1'b0; bus32.src_a = '0; bus32.src_b = '0;
    bus16.ALUOp = 2'b00; bus16.op5 = 1'b0; bus16.funct3 = 3'b000; bus16.funct7 = 7'b0;
    bus16.in_valid = 1'b0; bus16.flush = 1'b0; bus16.src_a = '0; bus16.src_b = '0;
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_xlen16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_muldiv.md
# alu_ctrl_muldiv

Parametrised ALU control unit for the execute stage. It replaces the 3-bit combinational ALU decoder with a 4-bit control decoder that covers every RV32I ALU and branch operation, including sltu and sra. It also adds an iterative multiply/divide engine for the RV32M instructions. The engine holds the pipeline through a stall output while it runs.

## Interface
Parameters:
- XLEN, 32: operand and result width. Must be ≥ 8.
- CW, 4: ALUControl width. Fixed at 4 and exported from the package.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- ALUOp  in  2  main-decoder class:
  - 00 load/store
  - 01 branch
  - 10 ALU
  - 11 invalid
- op5  in  1  opcode bit 5. 1 = R-type, 0 = I-type.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- in_valid  in  1  the execute stage holds a live instruction.
- flush  in  1  aborts any multiply/divide in progress.
- src_a, src_b  in  XLEN  operands for the multiply/divide engine.
- ALUControl  out  CW  combinational ALU operation code.
- md_sel  out  1  the current instruction is RV32M. The writeback mux selects md_result when this is 1.
- stall  out  1  freezes the front of the pipeline.
- md_busy  out  1  the engine is not in IDLE.
- md_done  out  1  one-cycle pulse; md_result is valid in this cycle.
- md_result  out  XLEN  multiply/divide result.

## Operation
ALUControl codes:
- 0000 add
- 0001 sub
- 0010 and
- 0011 or
- 0100 xor
- 0101 slt
- 0110 sll
- 0111 srl
- 1000 sltu
- 1001 sra
- 1111 invalid

ALUControl decode:
- ALUOp 00 → add.
- ALUOp 01 (branch), selected by funct3:
  - 000/001 → sub
  - 100/101 → slt
  - 110/111 → sltu
  - 010/011 → invalid
- ALUOp 10, selected by funct3:
  - 000 → sub if op5 & funct7[5], otherwise add.
  - 001 → sll
  - 010 → slt
  - 011 → sltu
  - 100 → xor
  - 101 → sra if funct7[5], otherwise srl.
  - 110 → or
  - 111 → and
- ALUOp 11 → invalid.

RV32M selection:
- md_sel = (ALUOp==10) & op5 & (funct7==0000001).
- When md_sel is 1, ALUControl = add. The ALU result is ignored in this case.
- funct3 mapping:
  - 000 mul
  - 001 mulh
  - 010 mulhsu
  - 011 mulhu
  - 100 div
  - 101 divu
  - 110 rem
  - 111 remu

Engine state machine (IDLE, MUL, DIV, DONE):
- IDLE → MUL or DIV when in_valid & md_sel. Operands, sign flags and funct3 are latched. Signed operands are converted to magnitudes; signedness follows the funct3 mapping.
- MUL: radix-2 shift-add into a 2·XLEN product, XLEN iterations. The product is negated at the end if the operand signs differ.
- DIV: restoring division, XLEN iterations. Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Special cases skip iteration and go IDLE → DONE directly:
  - Divide by zero: quotient = all ones, remainder = src_a.
  - Signed overflow (a = −2^(XLEN−1), b = −1): quotient = src_a, remainder = 0.
- Result selection: mul returns the low half of the product; mulh, mulhsu and mulhu return the high half.
- DONE: md_done = 1, md_result is driven. The next state is always IDLE. The engine does not accept a new request in the DONE cycle.
- stall = in_valid & md_sel & ~md_done.
- flush, in any state: next state is IDLE and md_done is not asserted. flush has priority over acceptance.

## Timing
- ALUControl, md_sel and stall are combinational from the inputs.
- Normal latency:
  - Accept edge at cycle 0.
  - Iterations run in cycles 1..XLEN.
  - md_done is asserted in cycle XLEN+1.
  - stall is high for XLEN+1 cycles.
- Special-case latency: md_done is asserted in cycle 1.
- md_result holds its value after DONE until the next accept.
- Reset values:
  - State = IDLE.
  - md_busy = 0, md_done = 0.
  - md_result = 0.
  - Iteration counter = 0.
  - All datapath registers = 0.
- Reset asserted mid-operation drops the operation immediately; md_done is not asserted.
- The iteration counter is $clog2(XLEN)+1 bits wide and counts down. The last iteration is the cycle in which the counter reads 1.
- in_valid or operand changes while busy are ignored. The latched copies are used.

## Structure
- Package alu_pkg holds:
  - the alu_ctrl_e enum (CW bits);
  - the ALUOp localparams;
  - the RV32M funct3 and funct7 constants;
  - the md_state_e enum.
- Sub-module muldiv_iter contains the state machine and datapath. The top level contains the decoder plus the stall/md_sel glue.

## Test plan
- Decode sweep: every ALUOp × funct3 × funct7[5] × op5 combination → matches the code list. Examples:
  - ALUOp 10, funct3 101, funct7 0100000 → 1001.
  - ALUOp 01, funct3 110 → 1000.
- mul 7 × −3 and mulh 0x80000000 × 0x80000000:
  - mul → 0xFFFFFFEB.
  - mulh → 0x40000000.
  - md_done is asserted in cycle 33; stall is high in cycles 0–32.
- div −7 / 2 → 0xFFFFFFFD. rem → 0xFFFFFFFF. divu 100 / 7 → 14. remu → 2.
- Special cases, each with md_done asserted in cycle 1:
  - div 5 / 0 → 0xFFFFFFFF.
  - rem 5 / 0 → 5.
  - div 0x80000000 / −1 → 0x80000000.
  - rem 0x80000000 / −1 → 0.
- flush asserted in cycle 10 of a divu → IDLE in the next cycle; md_done is never asserted. A new mul is then accepted and completes correctly.
- rst_n pulsed low mid-mul → all outputs 0 immediately, asynchronously. After release the unit is IDLE.
- XLEN=16 build: mulhu 0xFFFF × 0xFFFF → 0xFFFE; md_done is asserted in cycle 17.
